memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Three-port arbiter and sequencer for the single-port ternary RAM. It sits between the RAM and its requesters: port 0 is the program loader, port 1 is the CPU core and port 2 is the debug/monitor port. It grants at most one memory command per cycle, registers that command onto the RAM, and routes read data back to the issuing port after the RAM latency. It replaces the static loader/CPU mux in the system top.

## Interface
Parameters:
- WORD_SIZE, 9, word width in trits; buses are 2*WORD_SIZE bits (2 bits per trit, passed through unmodified).
- MEM_ADDR_SIZE, 9, address width in trits; buses are 2*MEM_ADDR_SIZE bits.
- READ_LATENCY, 1, cycles from registered mem_read_enable to valid mem_read_data (1..4).
- MAX_BURST, 4, maximum consecutive grants to one locked port (1..15).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; clears all state.
- loader_priority  in  1  when 1, port 0 has absolute priority over round-robin.
- req  in  3  per-port command request, bit i = port i.
- we  in  3  per-port write (1) / read (0) qualifier, valid with req.
- lock  in  3  per-port burst hold request.
- addr  in  3*2*MEM_ADDR_SIZE  packed addresses, port i at slice i.
- wdata  in  3*2*WORD_SIZE  packed write data, port i at slice i.
- gnt  out  3  one-hot (or zero) grant; req[i]&gnt[i] = command accepted this cycle.
- rvalid  out  3  one-hot read-return strobe.
- rdata  out  2*WORD_SIZE  read data, broadcast; qualified by rvalid.
- mem_write_enable  out  1  registered RAM write strobe.
- mem_read_enable  out  1  registered RAM read strobe.
- mem_address  out  2*MEM_ADDR_SIZE  registered RAM address.
- mem_write_data  out  2*WORD_SIZE  registered RAM write data.
- mem_read_data  in  2*WORD_SIZE  RAM read data.

## Operation
- State: 2-bit round-robin pointer rr (last granted port), 2-bit owner, 4-bit burst counter bcnt, READ_LATENCY+1-deep tag pipeline (valid bit + 2-bit port id per stage).
- Grant is combinational from req, lock, loader_priority, rr, owner and bcnt. It is computed in this order:
  - Lock hold: if req[owner] & lock[owner] & bcnt < MAX_BURST, grant owner (overrides loader_priority).
  - Loader priority: else if loader_priority & req[0], grant port 0.
  - Round-robin: else grant the first requesting port in order rr+1, rr+2, rr (mod 3).
  - No requests: gnt = 0, and rr, owner and bcnt hold.
- On an accepted grant to port g:
  - rr <= g and owner <= g.
  - bcnt <= bcnt+1 if g == previous owner and that port was granted last cycle; otherwise bcnt <= 1.
  - If bcnt reaches MAX_BURST, the lock is ignored and port g is last in round-robin order next cycle.
- Command register: on acceptance, the next cycle drives mem_address/mem_write_data from port g and pulses mem_write_enable = we[g] or mem_read_enable = ~we[g]. With no acceptance, both enables are 0 and address/data hold.
- Read return: a read pushes {1, g} into the tag pipeline. When the tag emerges READ_LATENCY cycles after the enable, rvalid[g] = 1 and rdata = mem_read_data. Tag pipeline is registered, so rvalid/rdata are registered outputs.
- Writes generate no response.
- Reads and writes from different ports interleave freely. The RAM is single-port, so there is no reordering and returns are in issue order.

## Timing
- Reset values: gnt = 0, rvalid = 0, rdata = 0, mem_write_enable = 0, mem_read_enable = 0, mem_address = 0, mem_write_data = 0, rr = 2 (port 0 first after reset), owner = 0, bcnt = 0, all tags invalid.
- Reset mid-operation: in-flight reads are discarded, no rvalid is issued for them, and a command registered in the reset cycle is dropped.
- Acceptance at cycle T -> RAM enable at T+1 -> rvalid at T+2+READ_LATENCY-1 = T+1+READ_LATENCY.
- Throughput: one command per cycle sustained, any mix of ports.
- Handshake: the requester holds req/we/addr/wdata stable until it sees gnt. Dropping req before gnt is legal (command withdrawn).
- A port that drops lock finishes its burst immediately; round-robin resumes the next cycle.
- Lock with req = 0 does not hold the grant.
- Simultaneous read return and new acceptance in the same cycle are independent.
- No deadlock: any port with req held stays ungranted for at most 2*MAX_BURST + 2 cycles, excluding loader_priority phases.

## Test plan
- Reset then single read: port 1 reads addr 5 at T with RAM holding 0x2A at 5 -> gnt[1] at T, mem_read_enable at T+1, rvalid[1] with rdata = 0x2A at T+2 (READ_LATENCY = 1); all other outputs 0.
- Round-robin fairness: req = 3'b111, no lock, held for 6 cycles -> grant sequence 0,1,2,0,1,2.
- Burst limit: port 2 req+lock with port 0 also requesting, MAX_BURST = 4 -> four grants to port 2, then port 0, then port 2 again.
- Loader priority: loader_priority = 1, req = 3'b011 for 3 cycles -> gnt = 3'b001 every cycle; clearing it -> port 1 granted the next cycle.
- Back-to-back mixed traffic: port 0 writes 0x15 to addr 3 at T, port 1 reads addr 3 at T+1 -> rvalid[1] with rdata = 0x15 at T+2+READ_LATENCY.
- Reset mid-flight: read accepted at T, reset at T+1 -> no rvalid ever appears for it, and outputs match reset values at T+2.

Source files
------------

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Purpose  : Three-port arbiter and command sequencer for the single-port
//            ternary RAM. Port 0 = program loader, port 1 = CPU core,
//            port 2 = debug/monitor. Grants at most one command per cycle,
//            registers it onto the RAM and routes read data back to the
//            issuing port in issue order.
// Ports    : clock, reset           - clock / synchronous active-high reset
//            loader_priority        - port 0 wins over round-robin
//            req/we/lock [2:0]      - per-port request, write, burst hold
//            addr/wdata             - packed per-port address / write data
//            gnt [2:0]              - one-hot combinational grant
//            rvalid [2:0], rdata    - registered read return
//            mem_*                  - registered RAM command, RAM read data
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 9,
  parameter int READ_LATENCY  = 1,
  parameter int MAX_BURST     = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         loader_priority,
  input  logic [2:0]                   req,
  input  logic [2:0]                   we,
  input  logic [2:0]                   lock,
  input  logic [3*2*MEM_ADDR_SIZE-1:0] addr,
  input  logic [3*2*WORD_SIZE-1:0]     wdata,
  output logic [2:0]                   gnt,
  output logic [2:0]                   rvalid,
  output logic [2*WORD_SIZE-1:0]       rdata,
  output logic                         mem_write_enable,
  output logic                         mem_read_enable,
  output logic [2*MEM_ADDR_SIZE-1:0]   mem_address,
  output logic [2*WORD_SIZE-1:0]       mem_write_data,
  input  logic [2*WORD_SIZE-1:0]       mem_read_data
);

  localparam int         AW      = 2*MEM_ADDR_SIZE;
  localparam int         DW      = 2*WORD_SIZE;
  localparam logic [3:0] MAX_B   = 4'(MAX_BURST);

  logic [1:0] rr;            // last granted port
  logic [1:0] owner;         // port holding (or last holding) the burst
  logic [3:0] bcnt;          // consecutive grants to owner
  logic       granted_last;  // a grant was accepted in the previous cycle

  // Read tag pipeline; rvalid is the final stage held in one-hot form.
  logic       tag_v  [READ_LATENCY];
  logic [1:0] tag_id [READ_LATENCY];

  logic          gnt_any;
  logic [1:0]    gnt_idx;
  logic [1:0]    rr_c1, rr_c2;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Grant selection: lock hold, then loader priority, then round-robin.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    rr_c1   = next_port(rr);
    rr_c2   = next_port(rr_c1);
    if (!reset) begin
      if (req[owner] && lock[owner] && (bcnt < MAX_B)) begin
        gnt_any = 1'b1;
        gnt_idx = owner;
      end else if (loader_priority && req[0]) begin
        gnt_any = 1'b1;
        gnt_idx = 2'd0;
      end else if (req[rr_c1]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_c1;
      end else if (req[rr_c2]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_c2;
      end else if (req[rr]) begin
        gnt_any = 1'b1;
        gnt_idx = rr;
      end
    end
  end

  assign gnt = gnt_any ? (3'b001 << gnt_idx) : 3'b000;

  always_comb begin
    sel_addr  = addr[AW-1:0];
    sel_wdata = wdata[DW-1:0];
    case (gnt_idx)
      2'd1: begin
        sel_addr  = addr[2*AW-1:AW];
        sel_wdata = wdata[2*DW-1:DW];
      end
      2'd2: begin
        sel_addr  = addr[3*AW-1:2*AW];
        sel_wdata = wdata[3*DW-1:2*DW];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr               <= 2'd2;
      owner            <= 2'd0;
      bcnt             <= 4'd0;
      granted_last     <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      rvalid           <= 3'b000;
      rdata            <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= 2'd0;
      end
    end else begin
      granted_last     <= gnt_any;
      mem_write_enable <= gnt_any & we[gnt_idx];
      mem_read_enable  <= gnt_any & ~we[gnt_idx];
      if (gnt_any) begin
        rr             <= gnt_idx;
        owner          <= gnt_idx;
        mem_address    <= sel_addr;
        mem_write_data <= sel_wdata;
        // Count only back-to-back grants to the same port; saturate so a
        // long-running sole requester cannot wrap back into lock hold.
        if (granted_last && (gnt_idx == owner))
          bcnt <= (bcnt == 4'hF) ? bcnt : bcnt + 4'd1;
        else
          bcnt <= 4'd1;
      end

      tag_v[0]  <= gnt_any & ~we[gnt_idx];
      tag_id[0] <= gnt_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end

      // RAM data is sampled on the READ_LATENCY-th edge after the enable
      // edge, aligned with the tag leaving the last pipeline stage.
      rvalid <= tag_v[READ_LATENCY-1] ? (3'b001 << tag_id[READ_LATENCY-1]) : 3'b000;
      if (tag_v[READ_LATENCY-1])
        rdata <= mem_read_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Purpose  : Directed self-checking bench for memory_arbiter with a small
//            RAM model (combinational read on the registered address, write
//            on the clock edge while mem_write_enable is high).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

  localparam int AW = 18;
  localparam int DW = 18;

  logic          clock = 1'b0;
  logic          reset;
  logic          loader_priority;
  logic [2:0]    req, we, lock;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          mem_write_enable, mem_read_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  logic [DW-1:0] ram [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  memory_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .loader_priority  (loader_priority),
    .req              (req),
    .we               (we),
    .lock             (lock),
    .addr             (addr),
    .wdata            (wdata),
    .gnt              (gnt),
    .rvalid           (rvalid),
    .rdata            (rdata),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  assign mem_read_data = ram[mem_address[3:0]];

  always @(posedge clock)
    if (mem_write_enable) ram[mem_address[3:0]] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 3'b000; we = 3'b000; lock = 3'b000; loader_priority = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  logic [2:0] exp_rr [6];
  logic [2:0] exp_burst [8];

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = DW'(i * 7 + 1);
    ram[5] = 18'h2A;
    addr = '0; wdata = '0;
    req = 3'b000; we = 3'b000; lock = 3'b000; loader_priority = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    // Reset state, with every port requesting: no grant during reset.
    req = 3'b111;
    #1;
    check("reset_gnt",    32'(gnt), 32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_rdata",  32'(rdata), 32'h0);
    check("reset_we",     32'(mem_write_enable), 32'h0);
    check("reset_re",     32'(mem_read_enable), 32'h0);
    check("reset_addr",   32'(mem_address), 32'h0);
    check("reset_wdata",  32'(mem_write_data), 32'h0);
    req = 3'b000;
    reset = 1'b0;

    // Single read: port 1 reads address 5.
    set_port(1, 18'd5, 18'd0);
    req = 3'b010; we = 3'b000;
    #1 check("rd_gnt", 32'(gnt), 32'h2);
    tick();
    req = 3'b000;
    #1;
    check("rd_re",      32'(mem_read_enable), 32'h1);
    check("rd_we",      32'(mem_write_enable), 32'h0);
    check("rd_addr",    32'(mem_address), 32'd5);
    check("rd_rvalid0", 32'(rvalid), 32'h0);
    tick();
    check("rd_rvalid",  32'(rvalid), 32'h2);
    check("rd_rdata",   32'(rdata), 32'h2A);
    check("rd_re_off",  32'(mem_read_enable), 32'h0);
    tick();
    check("rd_rvalid_off", 32'(rvalid), 32'h0);

    // Round-robin fairness (writes to address 0 to keep returns quiet).
    do_reset();
    addr = '0; wdata = '0;
    exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100;
    exp_rr[3] = 3'b001; exp_rr[4] = 3'b010; exp_rr[5] = 3'b100;
    for (int i = 0; i < 6; i++) begin
      req = 3'b111; we = 3'b111; lock = 3'b000;
      #1 check($sformatf("rr_%0d", i), 32'(gnt), 32'(exp_rr[i]));
      tick();
    end
    check("rr_no_rvalid", 32'(rvalid), 32'h0);

    // Burst limit: port 2 locks, port 0 competes; then port 2 drops lock.
    do_reset();
    req = 3'b100; we = 3'b111; lock = 3'b100;
    #1 check("burst_first", 32'(gnt), 32'h4);
    tick();
    exp_burst[0] = 3'b100; exp_burst[1] = 3'b100; exp_burst[2] = 3'b100;
    exp_burst[3] = 3'b001; exp_burst[4] = 3'b100; exp_burst[5] = 3'b100;
    for (int i = 0; i < 6; i++) begin
      req = 3'b101; lock = 3'b100;
      #1 check($sformatf("burst_%0d", i), 32'(gnt), 32'(exp_burst[i]));
      tick();
    end
    lock = 3'b000;
    #1 check("burst_unlock", 32'(gnt), 32'h1);
    tick();

    // Lock asserted without req does not hold the grant.
    do_reset();
    req = 3'b100; lock = 3'b100; we = 3'b111;
    #1 check("lk_first", 32'(gnt), 32'h4);
    tick();
    req = 3'b010;
    #1 check("lk_noreq", 32'(gnt), 32'h2);
    tick();

    // Loader priority.
    do_reset();
    loader_priority = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req = 3'b011; we = 3'b011;
      #1 check($sformatf("ldr_%0d", i), 32'(gnt), 32'h1);
      tick();
    end
    loader_priority = 1'b0;
    #1 check("ldr_release", 32'(gnt), 32'h2);
    tick();

    // Back-to-back write then read of the same address.
    do_reset();
    tick();
    set_port(0, 18'd3, 18'h15);
    set_port(1, 18'd3, 18'd0);
    req = 3'b001; we = 3'b001;
    #1 check("mix_gnt0", 32'(gnt), 32'h1);
    tick();
    req = 3'b010; we = 3'b000;
    #1;
    check("mix_gnt1",  32'(gnt), 32'h2);
    check("mix_we",    32'(mem_write_enable), 32'h1);
    check("mix_waddr", 32'(mem_address), 32'd3);
    check("mix_wdata", 32'(mem_write_data), 32'h15);
    tick();
    req = 3'b000;
    #1;
    check("mix_re",     32'(mem_read_enable), 32'h1);
    check("mix_rvalid0", 32'(rvalid), 32'h0);
    tick();
    check("mix_rvalid", 32'(rvalid), 32'h2);
    check("mix_rdata",  32'(rdata), 32'h15);

    // Reset while a read is in flight.
    tick();
    set_port(1, 18'd5, 18'd0);
    req = 3'b010; we = 3'b000;
    #1 check("rst_gnt", 32'(gnt), 32'h2);
    tick();
    req = 3'b000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata",  32'(rdata), 32'h0);
    check("rst_re",     32'(mem_read_enable), 32'h0);
    check("rst_we",     32'(mem_write_enable), 32'h0);
    check("rst_addr",   32'(mem_address), 32'h0);
    check("rst_wdata",  32'(mem_write_data), 32'h0);
    check("rst_gnt0",   32'(gnt), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_quiet_%0d", i), 32'(rvalid), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
